// File: rtl/mcs_sampler_if.sv
// mcs_sampler_if: stream bundle between the producers, the sampler and the packetiser.
//
// Signals:
//   in_valid  [CHANNELS]        per-channel sample request (producer -> sampler)
//   in_data   [CHANNELS*WIDTH]  channel i at bits [i*WIDTH +: WIDTH]
//   in_ready  [CHANNELS]        per-channel accept (sampler -> producer)
//   out_valid / out_ready       registered output stream handshake
//   out_data  [WIDTH]           sample data
//   out_chan  [CH_W]            source channel of out_data
//   out_ts    [TS_W]            capture timestamp, present only with MCS_TIMESTAMP_EN
//
// Modports: master = producers + downstream side (testbench), slave = sampler side.
// Optional feature macro: MCS_TIMESTAMP_EN.
interface mcs_sampler_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4
`ifdef MCS_TIMESTAMP_EN
    ,
    parameter int unsigned TS_W     = 16
`endif
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [CH_W-1:0]           out_chan;
`ifdef MCS_TIMESTAMP_EN
    logic [TS_W-1:0]           out_ts;
`endif

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
`ifdef MCS_TIMESTAMP_EN
        , input out_ts
`endif
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
`ifdef MCS_TIMESTAMP_EN
        , output out_ts
`endif
    );
endinterface

// File: rtl/mcs_sampler.sv
// mcs_sampler: multi-channel rate-limited sampler.
//
// Each channel has a saturating cycle counter and a one-entry holding slot. A channel is
// ready when its counter has reached thr and its slot is empty. Full slots drain through a
// round-robin arbiter into a registered valid/ready output tagged with the channel index.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous, active-high reset
//   thr   minimum cycles between accepted samples (shared by all channels)
//   bus   mcs_sampler_if.slave: per-channel inputs and the output stream
//
// Optional feature macro: MCS_TIMESTAMP_EN adds a free-running TS_W-bit timestamp that is
// captured with each sample and forwarded on out_ts.
module mcs_sampler #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned THR_W    = 8
`ifdef MCS_TIMESTAMP_EN
    ,
    parameter int unsigned TS_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [THR_W-1:0] thr,
    mcs_sampler_if.slave     bus
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [THR_W-1:0] CntMax = {THR_W{1'b1}};

    logic [THR_W-1:0]    cnt_q       [CHANNELS];
    logic [THR_W-1:0]    cnt_d       [CHANNELS];
    logic [WIDTH-1:0]    slot_data_q [CHANNELS];
    logic [WIDTH-1:0]    slot_data_d [CHANNELS];
    logic [CHANNELS-1:0] slot_full_q, slot_full_d;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [CH_W-1:0]     out_chan_q, out_chan_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
`ifdef MCS_TIMESTAMP_EN
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [TS_W-1:0]     slot_ts_q [CHANNELS];
    logic [TS_W-1:0]     slot_ts_d [CHANNELS];
    logic [TS_W-1:0]     out_ts_q, out_ts_d;
`endif

    logic [CHANNELS-1:0] in_ready;
    logic [CHANNELS-1:0] accept;
    logic                grant_vld;
    logic [CH_W-1:0]     grant_idx;
    logic                load;

    // Round-robin: first full slot strictly after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        logic [CH_W-1:0] j;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        j         = '0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            idx = (32'(rr_ptr_q) + k) % CHANNELS;
            j   = CH_W'(idx);
            if (!grant_vld && slot_full_q[j]) begin
                grant_vld = 1'b1;
                grant_idx = j;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // Registered state only: a slot freed this cycle cannot be refilled until next.
            in_ready[i] = (cnt_q[i] >= thr) && !slot_full_q[i];
        end
        accept = bus.in_valid & in_ready;
        load   = (!out_valid_q || bus.out_ready) && grant_vld;

        cnt_d       = cnt_q;
        slot_data_d = slot_data_q;
        slot_full_d = slot_full_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef MCS_TIMESTAMP_EN
        ts_d        = ts_q + TS_W'(1);
        slot_ts_d   = slot_ts_q;
        out_ts_d    = out_ts_q;
`endif

        // Granted slot is full, accepted slot is empty: the two never hit the same channel.
        if (load) begin
            slot_full_d[grant_idx] = 1'b0;
            rr_ptr_d               = grant_idx;
            out_chan_d             = grant_idx;
            out_data_d             = slot_data_q[grant_idx];
            out_valid_d            = 1'b1;
`ifdef MCS_TIMESTAMP_EN
            out_ts_d               = slot_ts_q[grant_idx];
`endif
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            if (accept[i]) begin
                cnt_d[i]       = '0;
                slot_data_d[i] = bus.in_data[i*WIDTH +: WIDTH];
                slot_full_d[i] = 1'b1;
`ifdef MCS_TIMESTAMP_EN
                slot_ts_d[i]   = ts_q;
`endif
            end else if (cnt_q[i] != CntMax) begin
                cnt_d[i] = cnt_q[i] + THR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]       <= '0;
                slot_data_q[i] <= '0;
            end
            slot_full_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= CH_W'(CHANNELS - 1);
`ifdef MCS_TIMESTAMP_EN
            ts_q        <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                slot_ts_q[i] <= '0;
            end
            out_ts_q    <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            slot_data_q <= slot_data_d;
            slot_full_q <= slot_full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef MCS_TIMESTAMP_EN
            ts_q        <= ts_d;
            slot_ts_q   <= slot_ts_d;
            out_ts_q    <= out_ts_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
`ifdef MCS_TIMESTAMP_EN
    assign bus.out_ts    = out_ts_q;
`endif
endmodule
